cache_way_line: RTL and testbench
=================================

// Module: cache_way_line
// PURPOSE
//  One way of the N-way set-associative data cache, with multi-word lines and its own tag/valid/dirty store.
//  Performs 1-cycle lookups with sized, sign/zero-extending loads and byte-lane stores.
//  Runs a dirty-line eviction and a beat-by-beat line refill when the cache controller selects this way.
//  Sits between the cache controller (lookup, victim select) and the main-memory burst port.
// PARAMETERS
//  ADDR_W          32  byte address width
//  SETS            64  lines per way; power of 2, >=2
//  WORDS_PER_LINE  4   32-bit words per line; power of 2, >=2
//  derived: WO_W=log2(WORDS_PER_LINE), IDX_W=log2(SETS), TAG_W=ADDR_W-2-WO_W-IDX_W
//  addr = {tag, index, word_off, byte_off[1:0]}
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  req_valid    in   1       lookup request
//  req_ready    out  1       state==IDLE && !fill_start (combinational)
//  req_we       in   1       1=store, 0=load
//  req_mode     in   3       000 word, 001 half, 010 byte, 011 ubyte, 100 uhalf
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-aligned
//  resp_valid   out  1       1-cycle pulse, cycle after accept
//  resp_hit     out  1       valid && tag match
//  resp_rdata   out  32      extracted load data; 0 on store or miss
//  fill_start   in   1       controller selects this way for refill; sampled in IDLE only
//  fill_addr    in   ADDR_W  line address to refill; word/byte offset ignored
//  evict_valid  out  1       victim beat valid
//  evict_ready  in   1       memory accepts victim beat
//  evict_addr   out  ADDR_W  victim line base address {old_tag, index, 0}
//  evict_data   out  32      victim word [evict counter]
//  fill_valid   in   1       refill beat from memory
//  fill_data    in   32      refill word, line order 0..WORDS_PER_LINE-1
//  fill_done    out  1       1-cycle pulse, line installed
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): valid[]/dirty[] all 0; FSM=IDLE; counters 0; all outputs 0; data/tag arrays not reset.
//  FSM: IDLE -> (fill_start & valid & dirty[idx]) EVICT | (fill_start otherwise) FILL.
//  EVICT -> FILL after last beat; FILL -> DONE after last beat; DONE -> IDLE (fill_done=1 here).
//  Lookup: accepted when req_valid & req_ready; compare is combinational on arrays; result registered.
//  resp_valid/resp_hit/resp_rdata appear on cycle N+1.
//  Store hit: data written at end of accept cycle, byte lanes per mode; dirty[idx] set.
//    Word: all 4 lanes. Half/uhalf: lanes {addr[1],1'b0}+1..+0. Byte/ubyte: lane addr[1:0]. Little-endian.
//    Store miss: no array change (no write-allocate here).
//  Load: half/uhalf select by addr[1]; byte/ubyte by addr[1:0]; 001/010 sign-extend, 011/100 zero-extend.
//    addr[0] ignored for halves; modes 101-111 behave as word.
//  Load after store to same word on next accept sees new data.
//  EVICT: evict_valid=1; evict_addr/data stable until evict_ready; counter advances on valid&ready.
//  FILL: each fill_valid cycle writes fill_data to word[counter], counter++.
//    On last beat: tag<=fill tag, valid=1, dirty=0. fill_valid outside FILL ignored.
//  Counters wrap to 0 at WORDS_PER_LINE; fill index/tag latched at fill_start, not re-sampled.
//  fill_start and req_valid same IDLE cycle: fill wins, request not accepted (req_ready=0).
//  Reset mid-EVICT/FILL: line left invalid (all valid cleared), FSM IDLE, no fill_done.
// TESTING
//  T1 reset, load word 0x100 -> resp_valid@N+1, resp_hit=0, resp_rdata=0.
//  T2 fill 0x100 (clean, 4 beats 0x11..0x44) -> no evict_valid, fill_done 1 cycle after 4th beat.
//    Then load word 0x104 -> hit, 0x22.
//  T3 store byte 0x80 @0x107; load byte 0x107 -> 0xFFFFFF80; ubyte -> 0x80; word 0x104 -> 0x80000022.
//  T4 fill 0x100 tag' same index while dirty -> 4 evict beats, evict_addr=0x100, data 0x11,0x80000022,0x33,0x44.
//    evict_ready stalled 3 cycles on beat 1 with data held; then FILL.
//  T5 fill_start+req_valid same cycle -> req_ready=0, no resp; reset asserted after 2 fill beats
//    -> busy=0, lookup of that line misses.

Source files
------------

// File: rtl/cache_way_line.sv
// One way of a set-associative data cache: tag/valid/dirty store, multi-word
// lines, 1-cycle sized lookups, and a line engine that evicts a dirty victim
// and then refills the line beat by beat from the memory burst port.
//
// Handshake semantics: a beat or request transfers on a cycle where its valid
// and ready are both high. The source holds its payload stable while valid is
// high and ready is low, and the sink never depends on valid to raise ready.
module cache_way_line #(
  parameter int ADDR_W         = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [31:0]       resp_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              evict_valid,
  input  logic              evict_ready,
  output logic [ADDR_W-1:0] evict_addr,
  output logic [31:0]       evict_data,
  input  logic              fill_valid,
  input  logic [31:0]       fill_data,
  output logic              fill_done,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int WO_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - WO_W - IDX_W;
  localparam int DEPTH = SETS * WORDS_PER_LINE;
  localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WO_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [31:0]       data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [SETS];

  logic [IDX_W-1:0]  req_idx, fill_idx_in;
  logic [WO_W-1:0]   req_wo;
  logic [TAG_W-1:0]  req_tag, fill_tag_in;
  logic [31:0]       rd_word, load_data, store_word, wdata_rep;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [3:0]        byte_en;
  logic              lookup_hit, accept, store_we, tag_we;
  logic              mem_we;
  logic [IDX_W+WO_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [WO_W+1:0]   unused_fill_offset;

  assign req_idx     = req_addr[2+WO_W +: IDX_W];
  assign req_wo      = req_addr[2 +: WO_W];
  assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx_in = fill_addr[2+WO_W +: IDX_W];
  assign fill_tag_in = fill_addr[ADDR_W-1 -: TAG_W];
  assign unused_fill_offset = fill_addr[WO_W+1:0];

  // A pending fill_start takes priority over a lookup in the same cycle.
  assign req_ready  = (state_q == S_IDLE) && !fill_start;
  assign accept     = req_valid && req_ready;
  assign rd_word    = data_mem[{req_idx, req_wo}];
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign store_we   = accept && req_we && lookup_hit;

  // Load extraction and store lane merge for the addressed word.
  always_comb begin
    half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel = rd_word[8*req_addr[1:0] +: 8];
    case (req_mode)
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  load_data = {24'b0, byte_sel};
      3'b100:  load_data = {16'b0, half_sel};
      default: load_data = rd_word;
    endcase
    case (req_mode)
      3'b001, 3'b100: begin
        byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      3'b010, 3'b011: begin
        byte_en   = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = byte_en[i] ? wdata_rep[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Line engine next state: victim select, eviction beats, refill beats.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_we     = 1'b0;
    evict_valid = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          fill_idx_d = fill_idx_in;
          fill_tag_d = fill_tag_in;
          cnt_d      = '0;
          state_d    = (valid_q[fill_idx_in] && dirty_q[fill_idx_in]) ? S_EVICT : S_FILL;
        end
      end
      S_EVICT: begin
        evict_valid = 1'b1;
        if (evict_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d             = S_DONE;
            tag_we              = 1'b1;
            valid_d[fill_idx_q] = 1'b1;
            dirty_d[fill_idx_q] = 1'b0;
          end
        end
      end
      S_DONE: begin
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (store_we) dirty_d[req_idx] = 1'b1;
  end

  // Lookup result, registered for the cycle after accept.
  always_comb begin
    resp_valid_d = accept;
    resp_hit_d   = accept && lookup_hit;
    resp_rdata_d = (accept && lookup_hit && !req_we) ? load_data : 32'h0;
  end

  // Data array write port: store hits in IDLE, refill beats in FILL.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {req_idx, req_wo};
    mem_wdata = store_word;
    if (state_q == S_FILL && fill_valid) begin
      mem_we    = 1'b1;
      mem_waddr = {fill_idx_q, cnt_q};
      mem_wdata = fill_data;
    end else if (store_we) begin
      mem_we = 1'b1;
    end
  end

  // Data and tag arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_waddr] <= mem_wdata;
    if (tag_we) tag_mem[fill_idx_q] <= fill_tag_q;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_idx_q   <= fill_idx_d;
      fill_tag_q   <= fill_tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign evict_addr = evict_valid ? {tag_mem[fill_idx_q], fill_idx_q, {(WO_W+2){1'b0}}} : '0;
  assign evict_data = evict_valid ? data_mem[{fill_idx_q, cnt_q}] : 32'h0;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_way_line.sv
// Directed bench for cache_way_line: a byte-array model of one way predicts
// every lookup response; one compare process checks the response port every
// cycle, and the line engine is checked beat by beat against the model.
module tb_cache_way_line;

  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [2:0]  req_mode = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        fill_start = 1'b0;
  logic [31:0] fill_addr = 32'h0;
  logic        evict_valid;
  logic        evict_ready = 1'b0;
  logic [31:0] evict_addr, evict_data;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_data = 32'h0;
  logic        fill_done, busy;
  logic [1:0]  dbg_state;

  cache_way_line dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_done(fill_done), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard: {hit, rdata} per accepted request, and the cycle it is due.
  logic [32:0] exp_q[$];
  int unsigned due_q[$];
  logic [31:0] ev_log[$];
  logic [31:0] ev_addr_log;

  // Behavioural model of the way, byte-addressed per line.
  logic        m_valid [SETS];
  logic        m_dirty [SETS];
  logic [21:0] m_tag   [SETS];
  logic [7:0]  m_bytes [SETS][16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[int'(a[9:4])] && (m_tag[int'(a[9:4])] == a[31:10]);
  endfunction

  function automatic logic [31:0] model_word(input int idx, input int w);
    return {m_bytes[idx][4*w+3], m_bytes[idx][4*w+2], m_bytes[idx][4*w+1], m_bytes[idx][4*w]};
  endfunction

  function automatic logic [32:0] predict(input logic we, input logic [2:0] mode, input logic [31:0] a);
    int idx, base, o;
    logic [31:0] v;
    idx  = int'(a[9:4]);
    base = int'(a[3:2]) * 4;
    v    = 32'h0;
    if (model_hit(a) && !we) begin
      case (mode)
        3'd1, 3'd4: begin
          o = base + (a[1] ? 2 : 0);
          v = {16'h0, m_bytes[idx][o+1], m_bytes[idx][o]};
          if (mode == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        3'd2, 3'd3: begin
          v = {24'h0, m_bytes[idx][base + int'(a[1:0])]};
          if (mode == 3'd2 && v[7]) v = v | 32'hFFFF_FF00;
        end
        default: v = model_word(idx, int'(a[3:2]));
      endcase
    end
    return {model_hit(a), v};
  endfunction

  function automatic void model_store(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] wd);
    int idx, base, o;
    idx  = int'(a[9:4]);
    base = int'(a[3:2]) * 4;
    if (!model_hit(a)) return;
    case (mode)
      3'd1, 3'd4: begin
        o = base + (a[1] ? 2 : 0);
        m_bytes[idx][o]   = wd[7:0];
        m_bytes[idx][o+1] = wd[15:8];
      end
      3'd2, 3'd3: m_bytes[idx][base + int'(a[1:0])] = wd[7:0];
      default: for (int k = 0; k < 4; k++) m_bytes[idx][base+k] = wd[8*k +: 8];
    endcase
    m_dirty[idx] = 1'b1;
  endfunction

  // Compare process: response port against the scoreboard on every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        check("resp_valid", resp_valid, 1);
        check("resp_hit", resp_hit, exp_q[0][32]);
        check("resp_rdata", resp_rdata, exp_q[0][31:0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check("resp_valid_quiet", resp_valid, 0);
      end
    end
  end

  // Driver: one lookup; optional literal pins the model's prediction.
  task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] a,
                        input logic [31:0] wd, input logic [32:0] pin_val, input string name);
    logic [32:0] p;
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = a; req_wdata = wd;
    @(negedge clk);
    check({name, "_ready"}, req_ready, 1);
    p = predict(we, mode, a);
    check({name, "_model"}, p, pin_val);
    exp_q.push_back(p);
    due_q.push_back(cyc + 1);
    if (we) model_store(mode, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Driver: line refill, with eviction beats checked when the model says dirty.
  task automatic do_fill(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input int nbeats,
                         input int stall_beat, input int stall_len, input string name);
    logic [31:0] d [4];
    logic [31:0] ev_addr, ev_data;
    int idx;
    logic ev;
    d = '{d0, d1, d2, d3};
    idx = int'(a[9:4]);
    ev = m_valid[idx] && m_dirty[idx];
    fill_start = 1'b1; fill_addr = a;
    @(negedge clk);
    check({name, "_ready_blocked"}, req_ready, 0);
    @(posedge clk); #1;
    fill_start = 1'b0; req_valid = 1'b0; fill_addr = 32'hFFFF_FFFF;
    ev_log.delete();
    if (ev) begin
      ev_addr = {m_tag[idx], 6'(idx), 4'b0};
      ev_addr_log = ev_addr;
      for (int b = 0; b < 4; b++) begin
        ev_data = model_word(idx, b);
        ev_log.push_back(ev_data);
        for (int s = 0; s < ((b == stall_beat) ? stall_len : 0); s++) begin
          @(negedge clk);
          check({name, "_ev_valid_stall"}, evict_valid, 1);
          check({name, "_ev_addr_stall"}, evict_addr, ev_addr);
          check({name, "_ev_data_stall"}, evict_data, ev_data);
          @(posedge clk); #1;
        end
        evict_ready = 1'b1;
        @(negedge clk);
        check({name, "_ev_valid"}, evict_valid, 1);
        check({name, "_ev_addr"}, evict_addr, ev_addr);
        check({name, "_ev_data"}, evict_data, ev_data);
        @(posedge clk); #1;
        evict_ready = 1'b0;
      end
    end else begin
      @(negedge clk);
      check({name, "_no_evict"}, evict_valid, 0);
      check({name, "_busy"}, busy, 1);
      @(posedge clk); #1;
    end
    for (int b = 0; b < nbeats; b++) begin
      if (b == 2) begin
        @(posedge clk); #1;
      end
      fill_valid = 1'b1; fill_data = d[b];
      @(negedge clk);
      check({name, "_fill_evict_low"}, evict_valid, 0);
      check({name, "_fill_done_low"}, fill_done, 0);
      check({name, "_fill_ready_low"}, req_ready, 0);
      @(posedge clk); #1;
      fill_valid = 1'b0;
    end
    if (nbeats == 4) begin
      @(negedge clk);
      check({name, "_fill_done"}, fill_done, 1);
      check({name, "_busy_done"}, busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_fill_done_pulse"}, fill_done, 0);
      check({name, "_idle"}, busy, 0);
      @(posedge clk); #1;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[31:10];
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 4; k++) m_bytes[idx][4*w+k] = d[w][8*k +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_evict_valid", evict_valid, 0);
    check("rst_evict_addr", evict_addr, 0);
    check("rst_evict_data", evict_data, 0);
    check("rst_fill_done", fill_done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // T1: cold lookup misses
    do_req(1'b0, 3'd0, 32'h100, 32'h0, {1'b0, 32'h0}, "t1_load_miss");

    // T2: clean fill then hit
    do_fill(32'h100, 32'h11, 32'h22, 32'h33, 32'h44, 4, -1, 0, "t2");
    fill_valid = 1'b1; fill_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    fill_valid = 1'b0;
    do_req(1'b0, 3'd0, 32'h104, 32'h0, {1'b1, 32'h22}, "t2_load");
    do_req(1'b0, 3'd0, 32'h10C, 32'h0, {1'b1, 32'h44}, "t2_load_w3");

    // T3: byte store and sized loads, back to back
    do_req(1'b1, 3'd2, 32'h107, 32'h80, {1'b1, 32'h0}, "t3_store_b");
    do_req(1'b0, 3'd2, 32'h107, 32'h0, {1'b1, 32'hFFFF_FF80}, "t3_load_b");
    do_req(1'b0, 3'd3, 32'h107, 32'h0, {1'b1, 32'h80}, "t3_load_ub");
    do_req(1'b0, 3'd0, 32'h104, 32'h0, {1'b1, 32'h8000_0022}, "t3_load_w");
    do_req(1'b1, 3'd0, 32'h900, 32'hCAFE_F00D, {1'b0, 32'h0}, "t3_store_miss");
    do_req(1'b0, 3'd0, 32'h100, 32'h0, {1'b1, 32'h11}, "t3_after_miss");
    do_req(1'b0, 3'd0, 32'h900, 32'h0, {1'b0, 32'h0}, "t3_load_miss");

    // T4: dirty victim evicted with a stalled beat, then refill
    do_fill(32'h500, 32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD0D1_D2D3, 4, 1, 3, "t4");
    check("t4_ev_count", ev_log.size(), 4);
    check("t4_ev_addr_pin", ev_addr_log, 32'h100);
    if (ev_log.size() == 4) begin
      check("t4_ev0_pin", ev_log[0], 32'h11);
      check("t4_ev1_pin", ev_log[1], 32'h8000_0022);
      check("t4_ev2_pin", ev_log[2], 32'h33);
      check("t4_ev3_pin", ev_log[3], 32'h44);
    end
    do_req(1'b0, 3'd0, 32'h500, 32'h0, {1'b1, 32'hA0A1_A2A3}, "t4_load_new");
    do_req(1'b0, 3'd0, 32'h104, 32'h0, {1'b0, 32'h0}, "t4_load_old");

    // Half-word lanes, reserved modes as word, ubyte store lane
    do_req(1'b1, 3'd1, 32'h50B, 32'h1234_8001, {1'b1, 32'h0}, "h_store_hi");
    do_req(1'b0, 3'd1, 32'h50A, 32'h0, {1'b1, 32'hFFFF_8001}, "h_load_half");
    do_req(1'b0, 3'd4, 32'h508, 32'h0, {1'b1, 32'h0000_C2C3}, "h_load_uhalf");
    do_req(1'b0, 3'd5, 32'h508, 32'h0, {1'b1, 32'h8001_C2C3}, "h_load_mode5");
    do_req(1'b1, 3'd7, 32'h50C, 32'h1234_5678, {1'b1, 32'h0}, "h_store_mode7");
    do_req(1'b0, 3'd0, 32'h50C, 32'h0, {1'b1, 32'h1234_5678}, "h_load_w");
    do_req(1'b0, 3'd2, 32'h50E, 32'h0, {1'b1, 32'h34}, "h_load_b2");
    do_req(1'b1, 3'd3, 32'h501, 32'h0000_01FE, {1'b1, 32'h0}, "h_store_ub");
    do_req(1'b0, 3'd0, 32'h500, 32'h0, {1'b1, 32'hA0A1_FEA3}, "h_load_w0");
    do_req(1'b0, 3'd4, 32'h502, 32'h0, {1'b1, 32'h0000_A0A1}, "h_load_uh_hi");

    // T5: fill beats a same-cycle request; reset mid-fill
    req_valid = 1'b1; req_we = 1'b0; req_mode = 3'd0; req_addr = 32'h2C0;
    do_fill(32'h2C0, 32'h1, 32'h2, 32'h3, 32'h4, 2, -1, 0, "t5");
    reset = 1'b0;
    #2;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_evict", evict_valid, 0);
    check("t5_rst_fill_done", fill_done, 0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_post_fill_done", fill_done, 0);
      check("t5_post_busy", busy, 0);
      @(posedge clk); #1;
    end
    do_req(1'b0, 3'd0, 32'h2C0, 32'h0, {1'b0, 32'h0}, "t5_line_miss");
    do_req(1'b0, 3'd0, 32'h500, 32'h0, {1'b0, 32'h0}, "t5_other_miss");
    do_fill(32'h2C0, 32'h1, 32'h2, 32'h3, 32'h4, 4, -1, 0, "t5_refill");
    do_req(1'b0, 3'd0, 32'h2C8, 32'h0, {1'b1, 32'h3}, "t5_refill_hit");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
